// File: rtl/gray_counter.sv
// gray_counter
//   Parametrised Gray-code counter with up/down counting, synchronous load
//   (binary or Gray-coded load value) and registered Gray/binary outputs.
//   Because the Gray output is loaded from the next-state value, it toggles
//   exactly one bit per counting step. This makes it suitable for pointers
//   that cross into other logic.
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   en            in   count enable, one step per edge while high
//   up            in   direction: 1 = increment, 0 = decrement
//   load          in   synchronous load, has priority over en
//   load_is_gray  in   1 = d is Gray-coded, 0 = d is binary
//   d             in   load value [WIDTH-1:0]
//   gray          out  registered count, Gray-coded [WIDTH-1:0]
//   bin           out  registered count, binary [WIDTH-1:0]
//   wrap          out  one-cycle pulse on a counting wrap-around
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_is_gray,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] d_g2b;

    // Gray-to-binary: each binary bit is the running XOR from the MSB down.
    always_comb begin
        d_g2b = '0;
        d_g2b[WIDTH-1] = d[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            d_g2b[i] = d_g2b[i+1] ^ d[i];
        end
    end

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_is_gray ? d_g2b : d;
        end else if (en) begin
            if (up) begin
                bin_d  = bin_q + ONE;
                wrap_d = (bin_q == ALL_ONES);
            end else begin
                bin_d  = bin_q - ONE;
                wrap_d = (bin_q == '0);
            end
        end
        // Gray is derived from the next state so that both outputs stay aligned
        // and gray comes straight from a flop.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
module tb_gray_counter;

    typedef struct {
        logic [7:0] g;
        logic [7:0] b;
        logic       w;
    } exp_t;

    logic clk = 1'b0;
    logic clk_run = 1'b0;
    logic rst_n;

    logic       en4, up4, ld4, lig4;
    logic [3:0] d4, gray4, bin4;
    logic       wrap4;

    logic       en8, up8, ld8, lig8;
    logic [7:0] d8, gray8, bin8;
    logic       wrap8;

    int checks = 0;
    int failures = 0;

    logic [7:0] m4 = 8'd0;
    logic [7:0] m8 = 8'd0;
    exp_t       sb[$];

    logic [7:0] gray_tab [16] = '{8'd0, 8'd1, 8'd3, 8'd2, 8'd6, 8'd7, 8'd5, 8'd4,
                                  8'd12, 8'd13, 8'd15, 8'd14, 8'd10, 8'd11, 8'd9, 8'd8};

    gray_counter #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .up(up4), .load(ld4),
        .load_is_gray(lig4), .d(d4), .gray(gray4), .bin(bin4), .wrap(wrap4)
    );

    gray_counter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .up(up8), .load(ld8),
        .load_is_gray(lig8), .d(d8), .gray(gray8), .bin(bin8), .wrap(wrap8)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    function automatic logic [7:0] g2b(input logic [7:0] g, input int w);
        logic [7:0] b;
        b = g;
        for (int s = 1; s < w; s++) b = b ^ (g >> s);
        return b;
    endfunction

    // Drives one cycle on the selected instance (other instance idles), pushes
    // the model's expectation, then pops it against the DUT after the edge.
    task automatic step(input int sel, input logic ld, input logic lig,
                        input logic [7:0] dv, input logic e, input logic u,
                        input string name);
        logic [7:0] mask, cur, nb;
        logic       wr;
        exp_t       ex, got;
        @(negedge clk);
        en4 = 0; ld4 = 0; en8 = 0; ld8 = 0;
        if (sel == 4) begin
            en4 = e; up4 = u; ld4 = ld; lig4 = lig; d4 = dv[3:0];
            mask = 8'h0F; cur = m4;
        end else begin
            en8 = e; up8 = u; ld8 = ld; lig8 = lig; d8 = dv;
            mask = 8'hFF; cur = m8;
        end
        wr = 1'b0;
        if (ld) begin
            nb = lig ? g2b(dv & mask, sel) : (dv & mask);
        end else if (e) begin
            if (u) begin
                nb = (cur + 8'd1) & mask;
                wr = (cur == mask);
            end else begin
                nb = (cur - 8'd1) & mask;
                wr = (cur == 8'd0);
            end
        end else begin
            nb = cur;
        end
        if (sel == 4) m4 = nb; else m8 = nb;
        ex.b = nb; ex.g = nb ^ (nb >> 1); ex.w = wr;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        ex = sb.pop_front();
        if (sel == 4) begin
            got.g = {4'd0, gray4}; got.b = {4'd0, bin4}; got.w = wrap4;
        end else begin
            got.g = gray8; got.b = bin8; got.w = wrap8;
        end
        checks++;
        if (got.g !== ex.g) begin
            failures++;
            $display("FAIL %s gray: got %0d expected %0d", name, got.g, ex.g);
        end
        checks++;
        if (got.b !== ex.b) begin
            failures++;
            $display("FAIL %s bin: got %0d expected %0d", name, got.b, ex.b);
        end
        checks++;
        if (got.w !== ex.w) begin
            failures++;
            $display("FAIL %s wrap: got %0b expected %0b", name, got.w, ex.w);
        end
        en4 = 0; ld4 = 0; en8 = 0; ld8 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        m4 = 8'd0;
        m8 = 8'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en4 = 1'($urandom); up4 = 1'($urandom); ld4 = 1'($urandom);
        lig4 = 1'($urandom); d4 = 4'($urandom);
        en8 = 1'($urandom); up8 = 1'($urandom); ld8 = 1'($urandom);
        lig8 = 1'($urandom); d8 = 8'($urandom);
        #3;
        checks++;
        if ({gray4, bin4, wrap4} !== 9'd0) begin
            failures++;
            $display("FAIL reset4: got gray=%0d bin=%0d wrap=%0b expected 0 0 0", gray4, bin4, wrap4);
        end
        checks++;
        if ({gray8, bin8, wrap8} !== 17'd0) begin
            failures++;
            $display("FAIL reset8: got gray=%0d bin=%0d wrap=%0b expected 0 0 0", gray8, bin8, wrap8);
        end
        en4 = 0; ld4 = 0; en8 = 0; ld8 = 0; up4 = 1; up8 = 1; lig4 = 0; lig8 = 0;
        d4 = 0; d8 = 0;
        rst_n = 1'b1;
        clk_run = 1'b1;
    endtask

    task automatic test_up_count();
        logic [3:0] prev;
        prev = gray4;
        for (int k = 1; k <= 16; k++) begin
            step(4, 0, 0, 8'd0, 1, 1, "up_count");
            checks++;
            if ({4'd0, gray4} !== gray_tab[k % 16]) begin
                failures++;
                $display("FAIL up_table step %0d: got gray %0d expected %0d", k, gray4, gray_tab[k % 16]);
            end
            checks++;
            if ($countones(prev ^ gray4) != 1) begin
                failures++;
                $display("FAIL one_bit step %0d: got %0d changed bits expected 1", k, $countones(prev ^ gray4));
            end
            prev = gray4;
        end
        checks++;
        if ({bin4, wrap4} !== 5'b0000_1) begin
            failures++;
            $display("FAIL up_wrap_end: got bin=%0d wrap=%0b expected 0 1", bin4, wrap4);
        end
    endtask

    task automatic test_down_wrap();
        do_reset();
        step(4, 0, 0, 8'd0, 1, 0, "down_wrap1");
        checks++;
        if ({bin4, gray4, wrap4} !== {4'd15, 4'd8, 1'b1}) begin
            failures++;
            $display("FAIL down_wrap1_const: got %0d/%0d/%0b expected 15/8/1", bin4, gray4, wrap4);
        end
        step(4, 0, 0, 8'd0, 1, 0, "down_wrap2");
        checks++;
        if ({bin4, gray4, wrap4} !== {4'd14, 4'd9, 1'b0}) begin
            failures++;
            $display("FAIL down_wrap2_const: got %0d/%0d/%0b expected 14/9/0", bin4, gray4, wrap4);
        end
    endtask

    task automatic test_gray_load();
        step(4, 1, 1, 8'b0000_1101, 0, 0, "gray_load");
        checks++;
        if ({bin4, gray4, wrap4} !== {4'd9, 4'd13, 1'b0}) begin
            failures++;
            $display("FAIL gray_load_const: got %0d/%0d/%0b expected 9/13/0", bin4, gray4, wrap4);
        end
        step(4, 1, 1, 8'b0000_1000, 0, 0, "gray_load_msb");
    endtask

    task automatic test_load_priority();
        step(4, 1, 0, 8'd15, 0, 0, "load_15");
        step(4, 1, 0, 8'd0, 1, 1, "load_over_en");
        checks++;
        if ({bin4, wrap4} !== {4'd0, 1'b0}) begin
            failures++;
            $display("FAIL load_mask_const: got bin=%0d wrap=%0b expected 0 0", bin4, wrap4);
        end
        step(4, 0, 0, 8'd0, 1, 0, "down_after_load");
        checks++;
        if ({bin4, wrap4} !== {4'd15, 1'b1}) begin
            failures++;
            $display("FAIL down_after_load_const: got bin=%0d wrap=%0b expected 15 1", bin4, wrap4);
        end
        step(4, 1, 0, 8'd15, 1, 0, "load_allones_masked");
    endtask

    task automatic test_back_to_back();
        step(4, 1, 0, 8'd5, 0, 0, "b2b_load");
        step(4, 0, 0, 8'd0, 1, 1, "b2b_en_hi");
        step(4, 0, 0, 8'd0, 0, 1, "b2b_en_lo");
        step(4, 0, 0, 8'd0, 1, 1, "b2b_en_hi2");
        step(4, 0, 0, 8'd0, 0, 0, "b2b_en_lo2");
        step(4, 0, 0, 8'd0, 1, 0, "b2b_dir_down");
        checks++;
        if (bin4 !== 4'd6) begin
            failures++;
            $display("FAIL dir_change: got bin %0d expected 6", bin4);
        end
    endtask

    task automatic test_wide_and_async_reset();
        logic [7:0] eb [3] = '{8'd255, 8'd0, 8'd1};
        logic [7:0] eg [3] = '{8'd128, 8'd0, 8'd1};
        int wraps;
        wraps = 0;
        step(8, 1, 0, 8'd254, 0, 0, "wide_load");
        for (int k = 0; k < 3; k++) begin
            step(8, 0, 0, 8'd0, 1, 1, "wide_up");
            if (wrap8) wraps++;
            checks++;
            if (bin8 !== eb[k] || gray8 !== eg[k]) begin
                failures++;
                $display("FAIL wide_const %0d: got %0d/%0d expected %0d/%0d", k, bin8, gray8, eb[k], eg[k]);
            end
        end
        checks++;
        if (wraps != 1) begin
            failures++;
            $display("FAIL wide_wrap_count: got %0d expected 1", wraps);
        end
        step(8, 1, 1, 8'hB4, 0, 0, "wide_gray_load");
        step(4, 1, 0, 8'd0, 0, 0, "pre_reset_load");
        step(4, 0, 0, 8'd0, 1, 0, "pre_reset_wrap");
        en4 = 1; up4 = 1; en8 = 1; up8 = 1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({gray4, bin4, wrap4} !== 9'd0) begin
            failures++;
            $display("FAIL async_reset4: got %0d/%0d/%0b expected 0/0/0", gray4, bin4, wrap4);
        end
        checks++;
        if ({gray8, bin8, wrap8} !== 17'd0) begin
            failures++;
            $display("FAIL async_reset8: got %0d/%0d/%0b expected 0/0/0", gray8, bin8, wrap8);
        end
        en4 = 0; en8 = 0;
        #1 rst_n = 1'b1;
        m4 = 8'd0;
        m8 = 8'd0;
        step(8, 0, 0, 8'd0, 1, 1, "post_reset_first_step");
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_wrap();
        test_gray_load();
        test_load_priority();
        test_back_to_back();
        test_wide_and_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
